// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM: command frame opcode field and codes.
package spi_ram_pkg;

    localparam int OPC_W = 2;

    typedef enum logic [OPC_W-1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } opcode_e;

endpackage

// File: rtl/spi_ram_array.sv
// Word storage for the SPI burst RAM: synchronous write, combinational read.
// Addresses at or beyond MEM_DEPTH are out of range: writes there are ignored
// and reads there return zero.
module spi_ram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Index width actually needed by the storage; never wider than ADDR_WIDTH.
    localparam int IDX_W = $clog2(MEM_DEPTH);
    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  w_in_range;
    logic                  r_in_range;

    assign w_in_range = {1'b0, waddr} < DEPTH_W;
    assign r_in_range = {1'b0, raddr} < DEPTH_W;

    // Store one word per enabled cycle, only when the address maps to a real word.
    // NOTE: storage has no reset on purpose; its contents are undefined after
    // power-up and must survive rst_n, and a reset would also block RAM inference.
    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem_q[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = r_in_range ? mem_q[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/spi_burst_ram.sv
// Command-decoded burst RAM behind the SPI slave deserialiser. Decodes one
// command frame per rx_valid cycle, keeps auto-incrementing write/read
// address counters, returns read data through a valid/ready output register
// and flags dropped reads in a sticky overrun bit.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  rd_overrun
);

    localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

    // Post-increment with wrap; anything at or past the last word wraps to 0.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if ({1'b0, a} >= LAST_W) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    opcode_e               opc;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic                  rd_accept;
    logic                  rd_drop;

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  rd_overrun_q, rd_overrun_d;

    assign opc      = opcode_e'(din[DATA_WIDTH+1 -: OPC_W]);
    assign payload  = din[DATA_WIDTH-1:0];
    assign cmd_addr = payload[ADDR_WIDTH-1:0];

    spi_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr_q),
        .wdata (payload),
        .raddr (raddr_q),
        .rdata (mem_rdata)
    );

    // Decode the command, advance address counters, run the output handshake
    // and the overrun flag.
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        dout_d       = dout_q;
        tx_valid_d   = tx_valid_q;
        rd_overrun_d = rd_overrun_q;
        mem_we       = 1'b0;
        rd_accept    = 1'b0;
        rd_drop      = 1'b0;

        if (rx_valid) begin
            case (opc)
                OP_SET_WADDR: waddr_d = cmd_addr;
                OP_WRITE: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) begin
                        waddr_d = next_addr(waddr_q);
                    end
                end
                OP_SET_RADDR: raddr_d = cmd_addr;
                OP_READ: begin
                    // A read may replace the held word only once it is consumed.
                    if (!tx_valid_q || tx_ready) begin
                        rd_accept = 1'b1;
                    end else begin
                        rd_drop = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (rd_accept) begin
            dout_d     = mem_rdata;
            tx_valid_d = 1'b1;
            if (AUTO_INC != 0) begin
                raddr_d = next_addr(raddr_q);
            end
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        // A new overrun beats a simultaneous clear.
        if (rd_drop) begin
            rd_overrun_d = 1'b1;
        end else if (ovr_clr) begin
            rd_overrun_d = 1'b0;
        end
    end

    // Register control state; rst_n aborts any burst and drops pending output.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q      <= '0;
            raddr_q      <= '0;
            dout_q       <= '0;
            tx_valid_q   <= 1'b0;
            rd_overrun_q <= 1'b0;
        end else begin
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            dout_q       <= dout_d;
            tx_valid_q   <= tx_valid_d;
            rd_overrun_q <= rd_overrun_d;
        end
    end

    assign dout       = dout_q;
    assign tx_valid   = tx_valid_q;
    assign rd_overrun = rd_overrun_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Bench for spi_burst_ram: three instances (default, MEM_DEPTH=200, AUTO_INC=0)
// share one stimulus stream and are compared against a per-instance array model.
module tb_spi_burst_ram;
    import spi_ram_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;
    logic       ovr_clr;
    logic [7:0] dout_w     [N];
    logic       tx_valid_w [N];
    logic       ovr_w      [N];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, one slot per instance.
    int         m_depth [N];
    bit         m_ainc  [N];
    logic [7:0] m_mem   [N][256];
    bit         m_known [N][256];
    int         m_wa    [N];
    int         m_ra    [N];
    logic [7:0] m_dout  [N];
    bit         m_dk    [N];
    bit         m_tv    [N];
    bit         m_ovr   [N];

    always #5 clk = ~clk;

    spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .ovr_clr(ovr_clr), .dout(dout_w[0]), .tx_valid(tx_valid_w[0]), .rd_overrun(ovr_w[0]));

    spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .ovr_clr(ovr_clr), .dout(dout_w[1]), .tx_valid(tx_valid_w[1]), .rd_overrun(ovr_w[1]));

    spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .ovr_clr(ovr_clr), .dout(dout_w[2]), .tx_valid(tx_valid_w[2]), .rd_overrun(ovr_w[2]));

    task automatic check(input string tag, input int idx, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s [u%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    endtask

    function automatic int nxt(input int i, input int a);
        return (a >= m_depth[i] - 1) ? 0 : a + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_wa[i]   = 0;
            m_ra[i]   = 0;
            m_dout[i] = 8'h00;
            m_dk[i]   = 1'b1;
            m_tv[i]   = 1'b0;
            m_ovr[i]  = 1'b0;
        end
    endtask

    // Apply one cycle's inputs to the model using the pre-edge state.
    task automatic model_cmd(input logic [1:0] opc, input logic [7:0] pl, input bit rxv,
                             input bit rdy, input bit clr);
        for (int i = 0; i < N; i++) begin
            bit old_tv   = m_tv[i];
            bit accepted = 1'b0;
            bit dropped  = 1'b0;
            if (rxv) begin
                if (opc == OP_SET_WADDR) begin
                    m_wa[i] = int'(pl);
                end else if (opc == OP_WRITE) begin
                    if (m_wa[i] < m_depth[i]) begin
                        m_mem[i][m_wa[i]]   = pl;
                        m_known[i][m_wa[i]] = 1'b1;
                    end
                    if (m_ainc[i]) m_wa[i] = nxt(i, m_wa[i]);
                end else if (opc == OP_SET_RADDR) begin
                    m_ra[i] = int'(pl);
                end else if (!old_tv || rdy) begin
                    accepted = 1'b1;
                    if (m_ra[i] < m_depth[i]) begin
                        m_dout[i] = m_mem[i][m_ra[i]];
                        m_dk[i]   = m_known[i][m_ra[i]];
                    end else begin
                        m_dout[i] = 8'h00;
                        m_dk[i]   = 1'b1;
                    end
                    m_tv[i] = 1'b1;
                    if (m_ainc[i]) m_ra[i] = nxt(i, m_ra[i]);
                end else begin
                    dropped  = 1'b1;
                    m_ovr[i] = 1'b1;
                end
            end
            if (!accepted && old_tv && rdy) m_tv[i] = 1'b0;
            if (clr && !dropped) m_ovr[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, " tx_valid"}, i, 32'(tx_valid_w[i]), 32'(m_tv[i]));
            check({tag, " rd_overrun"}, i, 32'(ovr_w[i]), 32'(m_ovr[i]));
            if (m_dk[i]) check({tag, " dout"}, i, 32'(dout_w[i]), 32'(m_dout[i]));
        end
    endtask

    // Drive one cycle (called just after a rising edge), then check after the next edge.
    task automatic step(input logic [1:0] opc, input logic [7:0] pl, input string tag,
                        input bit rxv = 1'b1, input bit rdy = 1'b1, input bit clr = 1'b0);
        din      = {opc, pl};
        rx_valid = rxv;
        tx_ready = rdy;
        ovr_clr  = clr;
        model_cmd(opc, pl, rxv, rdy, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_depth = '{256, 200, 256};
        m_ainc  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 256; a++) m_known[i][a] = 1'b0;
        end

        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        ovr_clr  = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Write burst A1..A3 starting at 0x10.
        step(OP_SET_WADDR, 8'h10, "set_waddr");
        step(OP_WRITE, 8'hA1, "wr_a1");
        step(OP_WRITE, 8'hA2, "wr_a2");
        step(OP_WRITE, 8'hA3, "wr_a3");

        // Read burst with tx_ready held high.
        step(OP_SET_RADDR, 8'h10, "set_raddr");
        step(OP_READ, 8'h00, "rd_burst0");
        check("burst A1", 0, 32'(dout_w[0]), 32'hA1);
        step(OP_READ, 8'h00, "rd_burst1");
        check("burst A2", 0, 32'(dout_w[0]), 32'hA2);
        step(OP_READ, 8'h00, "rd_burst2");
        check("burst A3", 0, 32'(dout_w[0]), 32'hA3);
        step(OP_READ, 8'h00, "drain", 1'b0, 1'b1);
        check("burst drained", 0, 32'(tx_valid_w[0]), 32'h0);

        // Backpressure, overrun, clear, resume.
        step(OP_SET_RADDR, 8'h10, "bp_set_raddr");
        step(OP_READ, 8'h00, "bp_rd", 1'b1, 1'b0);
        step(OP_READ, 8'h00, "bp_drop", 1'b1, 1'b0);
        check("bp hold A1", 0, 32'(dout_w[0]), 32'hA1);
        check("bp overrun", 0, 32'(ovr_w[0]), 32'h1);
        step(OP_READ, 8'h00, "bp_clr", 1'b0, 1'b0, 1'b1);
        check("bp cleared", 0, 32'(ovr_w[0]), 32'h0);
        step(OP_READ, 8'h00, "bp_resume", 1'b1, 1'b1);
        check("bp resume A2", 0, 32'(dout_w[0]), 32'hA2);
        step(OP_READ, 8'h00, "bp_drain", 1'b0, 1'b1);

        // Overrun set and clear in the same cycle: set wins.
        step(OP_READ, 8'h00, "sc_rd", 1'b1, 1'b0);
        step(OP_READ, 8'h00, "sc_drop_clr", 1'b1, 1'b0, 1'b1);
        check("set beats clear", 0, 32'(ovr_w[0]), 32'h1);
        step(OP_READ, 8'h00, "sc_idle", 1'b0, 1'b1, 1'b1);

        // Wrap-around and out-of-range (meaningful on the 200-word instance).
        step(OP_SET_WADDR, 8'd199, "wrap_set_w");
        step(OP_WRITE, 8'h55, "wrap_wr55");
        step(OP_WRITE, 8'h66, "wrap_wr66");
        step(OP_SET_RADDR, 8'd199, "wrap_set_r");
        step(OP_READ, 8'h00, "wrap_rd199");
        check("wrap mem199", 1, 32'(dout_w[1]), 32'h55);
        step(OP_READ, 8'h00, "wrap_rd0");
        check("wrap mem0", 1, 32'(dout_w[1]), 32'h66);
        step(OP_SET_RADDR, 8'd250, "oor_set_r");
        step(OP_READ, 8'h00, "oor_rd");
        check("oor reads 0", 1, 32'(dout_w[1]), 32'h00);
        step(OP_READ, 8'h00, "oor_wrap_rd");
        check("oor wraps to 0", 1, 32'(dout_w[1]), 32'h66);
        step(OP_READ, 8'h00, "wrap_drain", 1'b0, 1'b1);

        // Held address (checked on the AUTO_INC=0 instance).
        step(OP_SET_WADDR, 8'd5, "hold_set_w");
        step(OP_WRITE, 8'h11, "hold_wr11");
        step(OP_WRITE, 8'h22, "hold_wr22");
        step(OP_SET_RADDR, 8'd5, "hold_set_r");
        step(OP_READ, 8'h00, "hold_rd0");
        check("hold rd0", 2, 32'(dout_w[2]), 32'h22);
        step(OP_READ, 8'h00, "hold_rd1");
        check("hold rd1", 2, 32'(dout_w[2]), 32'h22);
        step(OP_READ, 8'h00, "hold_drain", 1'b0, 1'b1);

        // Asynchronous reset in the middle of a pending, overrun read.
        step(OP_SET_RADDR, 8'h10, "ar_set_r");
        step(OP_READ, 8'h00, "ar_rd", 1'b1, 1'b0);
        step(OP_READ, 8'h00, "ar_drop", 1'b1, 1'b0);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst tx_valid", 0, 32'(tx_valid_w[0]), 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(OP_SET_RADDR, 8'h10, "ar_set_r2");
        step(OP_READ, 8'h00, "ar_rd2");
        check("mem kept A1", 0, 32'(dout_w[0]), 32'hA1);
        check("mem kept A1", 1, 32'(dout_w[1]), 32'hA1);
        step(OP_READ, 8'h00, "ar_drain", 1'b0, 1'b1);

        // Fill memory with random data, then run random traffic.
        step(OP_SET_WADDR, 8'h00, "fill_set");
        for (int k = 0; k < 256; k++) step(OP_WRITE, 8'($urandom), "fill");
        for (int k = 0; k < 600; k++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), "rand",
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
